// File: rtl/bus_if_pkg.sv
// Shared definitions for the bus_if initiator: FSM encoding, active-low
// strobe levels, bus direction values, widths and the timeout default.
package bus_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_WAIT   = 2'd3
  } bus_state_e;

  // Levels for the active-low bus strobes (bus_req_, bus_as_, bus_grnt_, bus_rdy_)
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Values carried on bus_rw / req_rw
  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  localparam int unsigned ADDR_W          = 30;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  // True when an active-low strobe is driven to its asserted level
  function automatic logic is_asserted(input logic sig_n);
    return (sig_n == ENABLE_);
  endfunction

endpackage

// File: rtl/bus_if_wdt.sv
// WAIT-state watchdog for bus_if. Counts enabled cycles after a clear and
// flags the cycle in which the TIMEOUT_CYC-th enabled cycle is being spent.
// The count saturates rather than wrapping.
module bus_if_wdt
  import bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A zero limit is treated as one so the counter always has a terminal value
  localparam int unsigned      LIMIT = (TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC;
  localparam int unsigned      CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] SAT   = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Cycle counter: cleared on request, advanced while enabled, held at SAT
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != SAT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of enabled cycles already completed, so the
  // current cycle is the last permitted one once r_cnt reaches LIMIT-1
  always_comb begin
    expired = enable && (r_cnt >= LAST);
  end

endmodule

// File: rtl/bus_if.sv
// Single-master bus initiator. A core request is captured in IDLE, the bus
// is requested (REQ), one address-strobe cycle is issued (ACCESS) and the
// slave's ready is awaited (WAIT) under a watchdog. Completion pulses done
// (and latches read data); a watchdog expiry pulses err instead.
module bus_if
  import bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  bus_state_e        r_state;
  bus_state_e        w_state_nxt;

  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_complete;
  logic              w_timeout;
  logic              w_expired;
  logic              w_wdt_clear;
  logic              w_wdt_en;

  // A request is taken only in a quiet IDLE cycle: the cycle carrying the
  // done pulse belongs to the finished access, so a req_valid still held
  // from it is not mistaken for a new request.
  assign w_accept   = (r_state == ST_IDLE) && req_valid && !r_done;

  // bus_rdy_ only matters in WAIT; completion outranks a coincident expiry
  assign w_complete = (r_state == ST_WAIT) && is_asserted(bus_rdy_);
  assign w_timeout  = (r_state == ST_WAIT) && !is_asserted(bus_rdy_) && w_expired;

  bus_if_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdt (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_wdt_clear),
    .enable  (w_wdt_en),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (is_asserted(bus_grnt_)) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_complete || w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs: bus strobes, watchdog control and core stall
  always_comb begin
    bus_req_    = ENABLE_;
    bus_as_     = DISABLE_;
    w_wdt_clear = 1'b0;
    w_wdt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus_req_ = DISABLE_;
      end
      ST_REQ: begin
        bus_req_ = ENABLE_;
      end
      ST_ACCESS: begin
        bus_as_     = ENABLE_;
        w_wdt_clear = 1'b1;
      end
      ST_WAIT: begin
        w_wdt_en = 1'b1;
      end
      default: begin
        bus_req_ = DISABLE_;
      end
    endcase
    busy = (r_state != ST_IDLE) || (req_valid && !r_done);
  end

  // Request capture, read-data latch and one-cycle completion/abort pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rw      <= BUS_READ;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rw      <= req_rw;
        r_addr    <= req_addr;
        r_wr_data <= req_wr_data;
      end
      if (w_complete && (r_rw != BUS_WRITE)) begin
        r_rd_data <= bus_rd_data;
      end
      r_done <= w_complete;
      r_err  <= w_timeout;
    end
  end

  assign bus_rw      = r_rw;
  assign bus_addr    = r_addr;
  assign bus_wr_data = r_wr_data;
  assign rd_data     = r_rd_data;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_bus_if.sv
// Self-checking bench for bus_if: a reactive slave model, a scoreboard of
// expected access outcomes, and per-access timing checks.
module tb_bus_if;
  import bus_if_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_rw;
  logic [29:0] req_addr;
  logic [31:0] req_wr_data;
  logic        busy, done, err;
  logic [31:0] rd_data;
  logic        bus_req_, bus_as_, bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic        bus_grnt_   = 1'b1;
  logic        bus_rdy_    = 1'b1;
  logic [31:0] bus_rd_data = '0;

  always #5 clk = ~clk;

  bus_if #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_wr_data (req_wr_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rd_data     (rd_data),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        is_err;
    logic [31:0] rd;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] model_rd  = '0;
  int          gnt_dly   = 1;
  int          rdy_k     = 1;
  logic [31:0] slv_data  = '0;
  bit          rdy_noise = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_bus_req_"},    32'(bus_req_),    32'd1);
    chk({p, "_bus_as_"},     32'(bus_as_),     32'd1);
    chk({p, "_bus_rw"},      32'(bus_rw),      32'd1);
    chk({p, "_bus_addr"},    32'(bus_addr),    32'd0);
    chk({p, "_bus_wr_data"}, bus_wr_data,      32'd0);
    chk({p, "_rd_data"},     rd_data,          32'd0);
    chk({p, "_done"},        32'(done),        32'd0);
    chk({p, "_err"},         32'(err),         32'd0);
    chk({p, "_busy"},        32'(busy),        32'd0);
  endtask

  // Slave: grants in the g-th REQ cycle, signals ready in the r-th WAIT
  // cycle (r=0: never); optionally holds bus_rdy_ low outside WAIT.
  initial begin
    int  req_cnt = 0;
    int  wait_cnt = 0;
    bit  in_wait = 1'b0;
    forever begin
      @(negedge clk);
      bus_rd_data = slv_data;
      if (bus_req_ === 1'b1) begin
        req_cnt = 0; wait_cnt = 0; in_wait = 1'b0;
        bus_grnt_ = 1'b1;
        bus_rdy_  = rdy_noise ? 1'b0 : 1'b1;
      end else if (bus_as_ === 1'b0) begin
        in_wait = 1'b1; wait_cnt = 0;
        bus_grnt_ = 1'b1;
        bus_rdy_  = rdy_noise ? 1'b0 : 1'b1;
      end else if (in_wait) begin
        wait_cnt++;
        bus_rdy_ = (rdy_k != 0 && wait_cnt == rdy_k) ? 1'b0 : 1'b1;
      end else begin
        req_cnt++;
        bus_grnt_ = (req_cnt >= gnt_dly) ? 1'b0 : 1'b1;
        bus_rdy_  = rdy_noise ? 1'b0 : 1'b1;
      end
    end
  end

  // Scoreboard consumer: every done/err pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_end", {30'b0, done, err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_outcome", {30'b0, done, err}, e.is_err ? 32'd1 : 32'd2);
          chk("sb_rd_data", rd_data, e.rd);
        end
      end
    end
  end

  // One access. Called at a negedge; extra = idle cycles expected before
  // acceptance; hold keeps req_valid high and returns at the end cycle.
  task automatic do_txn(input logic rw, input logic [29:0] addr, input logic [31:0] wd,
                        input logic [31:0] sd, input int g, input int r,
                        input int extra, input bit hold);
    int cyc = 0, as_cnt = 0, as_cyc = 0, req_lo = 0, end_cyc = 0, bad = 0;
    bit seen_as = 1'b0, fin = 1'b0, exp_err;
    exp_err = (r == 0) || (r > TO);
    if (!exp_err && rw == BUS_READ) model_rd = sd;
    sb_q.push_back('{is_err: exp_err, rd: model_rd});
    gnt_dly = g; rdy_k = r; slv_data = sd;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wr_data = wd;
    #1;
    chk("busy_on_request", 32'(busy), (extra == 0) ? 32'd1 : 32'd0);
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!hold && cyc == 1 + extra) req_valid = 1'b0;
      if (bus_as_ === 1'b0) begin
        as_cnt++;
        if (!seen_as) as_cyc = cyc;
        seen_as = 1'b1;
      end else if (!seen_as && bus_req_ === 1'b0) begin
        req_lo++;
      end
      if (seen_as && done !== 1'b1 && err !== 1'b1)
        if (bus_addr !== addr || bus_wr_data !== wd || bus_rw !== rw) bad++;
      if (done === 1'b1 || err === 1'b1) begin
        fin = 1'b1;
        end_cyc = cyc;
      end
    end
    chk("end_within_bound", 32'(fin), 32'd1);
    chk("as_low_cycles", as_cnt, 32'd1);
    chk("req_low_before_as", req_lo, g);
    chk("as_cycle", as_cyc, 1 + extra + g);
    chk("end_cycle", end_cyc, 1 + extra + g + (exp_err ? TO : r) + 1);
    chk("bus_fields_stable", bad, 32'd0);
    chk("bus_req_released", 32'(bus_req_), 32'd1);
    chk("busy_at_end", 32'(busy), exp_err ? 32'(req_valid) : 32'd0);
    if (!hold) begin
      @(negedge clk);
      chk("pulse_single_cycle", {30'b0, done, err}, 32'd0);
    end
  endtask

  initial begin
    int cyc;
    int bad;
    reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wr_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);

    // minimum-latency read
    do_txn(BUS_READ, 30'h100, 32'h0, 32'hDEADBEEF, 1, 1, 0, 1'b0);

    // write with delayed grant; bus_rdy_ noise outside WAIT must be ignored
    rdy_noise = 1'b1;
    do_txn(BUS_WRITE, 30'h10, 32'h12345678, 32'h5555AAAA, 5, 2, 0, 1'b0);
    chk("write_keeps_rd_data", rd_data, 32'hDEADBEEF);
    rdy_noise = 1'b0;

    // slave never ready -> abort; then ready on the last permitted cycle
    do_txn(BUS_READ, 30'h20, 32'h0, 32'h13572468, 1, 0, 0, 1'b0);
    chk("timeout_keeps_rd_data", rd_data, 32'hDEADBEEF);
    do_txn(BUS_READ, 30'h24, 32'h0, 32'hCAFEF00D, 1, TO, 0, 1'b0);

    // reset during WAIT aborts silently
    gnt_dly = 1; rdy_k = 0; slv_data = 32'hFFFF0000;
    req_valid = 1'b1; req_rw = BUS_READ; req_addr = 30'h3; req_wr_data = '0;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (bus_as_ !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reached_access", 32'(bus_as_), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk_reset_vals("midrst");
    model_rd = '0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || err !== 1'b0 || bus_req_ !== 1'b1) bad++;
    end
    chk("midrst_quiet", bad, 32'd0);
    do_txn(BUS_READ, 30'h30, 32'h0, 32'h0BADC0DE, 2, 1, 0, 1'b0);

    // back-to-back reads with req_valid held high throughout
    do_txn(BUS_READ, 30'h40, 32'h0, 32'h11111111, 1, 1, 0, 1'b1);
    chk("b2b_first_rd", rd_data, 32'h11111111);
    do_txn(BUS_READ, 30'h44, 32'h0, 32'h22222222, 1, 1, 1, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_rd", rd_data, 32'h22222222);

    // mixed random accesses, including some timeouts
    rdy_noise = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_txn(logic'($urandom_range(0, 1)), 30'($urandom), $urandom, $urandom,
             $urandom_range(1, 3), $urandom_range(0, 5), 0, 1'b0);
    end
    rdy_noise = 1'b0;

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_if.md
BUS_IF -- requirements
Module: bus_if

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the maximum WAIT-state cycles before abort.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- req_valid  in  1  core access request
- req_rw  in  1  1=read, 0=write
- req_addr  in  30  word address
- req_wr_data  in  32  write data
- busy  out  1  core stall
- done  out  1  access-complete pulse
- err  out  1  timeout pulse
- rd_data  out  32  last read data
- bus_req_  out  1  bus request, active-low
- bus_grnt_  in  1  bus grant, active-low
- bus_as_  out  1  address strobe, active-low
- bus_rw  out  1  1=read, 0=write
- bus_addr  out  30  bus address
- bus_wr_data  out  32  bus write data
- bus_rd_data  in  32  slave read data
- bus_rdy_  in  1  slave ready, active-low
REQ-003 There SHALL be one clock, clk; reset SHALL be synchronous and active-low.

Function
REQ-004 The block SHALL be a bus initiator with states IDLE, REQ, ACCESS and WAIT.
REQ-005 In IDLE with req_valid=1, the block SHALL capture req_rw, req_addr and req_wr_data, and SHALL enter REQ on the next edge.
REQ-006 In REQ, bus_req_ SHALL be 0; on bus_grnt_=0 the block SHALL enter ACCESS, otherwise it SHALL stay in REQ indefinitely.
REQ-007 In ACCESS, bus_as_ SHALL be 0 for exactly one cycle with the captured bus_addr, bus_rw and bus_wr_data driven, and the block SHALL then enter WAIT.
REQ-008 bus_rdy_ SHALL be ignored in every state except WAIT.
REQ-009 In WAIT, on bus_rdy_=0 the block SHALL:
- latch bus_rd_data into rd_data (reads only);
- pulse done for one cycle;
- return to IDLE.
REQ-010 On a write, rd_data SHALL hold its previous value.
REQ-011 bus_req_ SHALL stay 0 from REQ through WAIT, and SHALL return to 1 on the cycle the block enters IDLE.
REQ-012 bus_addr, bus_rw and bus_wr_data SHALL hold the captured values from ACCESS through WAIT.
REQ-013 busy SHALL be combinational: 1 when state is not IDLE, or when state is IDLE and req_valid=1.
REQ-014 busy SHALL be 0 during the IDLE cycle in which done is registered high.
REQ-015 A req_valid arriving while busy was already high SHALL NOT be accepted; the core SHALL hold it until the block is in IDLE.
REQ-016 The WAIT cycle counter SHALL clear on WAIT entry and SHALL saturate, never wrap.
REQ-017 When the counter reaches TIMEOUT_CYC without bus_rdy_=0, the block SHALL pulse err for one cycle, leave rd_data unchanged, not pulse done, and return to IDLE.
REQ-018 If bus_rdy_=0 arrives in the same cycle the counter reaches TIMEOUT_CYC, completion SHALL win: done=1, err=0.
REQ-019 With immediate grant and a one-cycle slave, minimum latency SHALL be: request accepted at edge 0, REQ in cycle 1, ACCESS in cycle 2, WAIT with bus_rdy_=0 in cycle 3, done=1 in cycle 4 (IDLE).

Reset
REQ-020 With reset=0 at a clk edge, regardless of state, the block SHALL enter IDLE.
REQ-021 Reset SHALL set bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, rd_data=0, done=0, err=0, counter=0.
REQ-022 A reset applied mid-transaction SHALL abort it with no done or err pulse.

Structure
REQ-023 The shared package/header SHALL hold:
- state encodings;
- active-low ENABLE_/DISABLE_ constants;
- BUS_READ/BUS_WRITE values;
- the 30-bit word-address width;
- the TIMEOUT_CYC default.
REQ-024 The timeout counter SHALL be a sub-module, bus_if_wdt, with inputs clear and enable and output expired.

Verification
REQ-025 Read with immediate grant, slave rdy_ one cycle after as_, bus_rd_data=0xDEADBEEF -> done in cycle 4, rd_data=0xDEADBEEF, bus_as_ low exactly one cycle.
REQ-026 Write to addr 0x0000_0010, data 0x12345678, grant delayed 5 cycles -> bus_req_ low 5 cycles before ACCESS; bus_addr/bus_wr_data stable through WAIT; done pulses; rd_data unchanged.
REQ-027 TIMEOUT_CYC=4, slave never ready -> err pulses after 4 WAIT cycles; done=0; bus_req_=1 next cycle.
REQ-028 TIMEOUT_CYC=4, bus_rdy_=0 on the 4th WAIT cycle -> done=1, err=0.
REQ-029 reset=0 for one cycle in WAIT -> next cycle all outputs at reset values; no done/err; a new request completes normally.
REQ-030 req_valid held high continuously across two back-to-back reads -> second accepted only in the IDLE cycle after the first done; rd_data updates twice.
